// File: rtl/mmio_console_pkg.sv
// mmio_console shared definitions
// register offsets and bit positions
package mmio_console_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 9;

  localparam int CTRL_IRQ_EN       = 0;
  localparam int CTRL_IRQ_ON_EMPTY = 1;
  localparam int CTRL_W            = 2;

endpackage

// File: rtl/mmio_console_fifo.sv
// mmio_console byte fifo
// push accepted when full only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push & ~do_pop)
        cnt <= cnt + (AW+1)'(1);
      else if (do_pop & ~do_push)
        cnt <= cnt - (AW+1)'(1);
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_console.sv
// mmio_console top
// bus decode, status, cycle counter, ctrl, irq
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'hFFFF_0000,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wd,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        sel;
  logic              wr_tx;
  logic              wr_st;
  logic              wr_cy;
  logic              wr_ct;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              ovf;
  logic [31:0]       cycle;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       status;
  logic              unused_addr;

  assign hit   = (address[31:4] == BASE[31:4]);
  assign sel   = address[3:2];
  assign wr_tx = hit & MemWrite & (sel == OFF_TXDATA);
  assign wr_st = hit & MemWrite & (sel == OFF_STATUS);
  assign wr_cy = hit & MemWrite & (sel == OFF_CYCLE);
  assign wr_ct = hit & MemWrite & (sel == OFF_CTRL);
  assign unused_addr = ^address[1:0];

  assign tx_valid = ~empty;
  assign pop      = tx_valid & tx_ready;
  assign push_ok  = wr_tx & (~full | pop);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .din   (wd[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  // occupancy after this edge, for irq
  always_comb begin
    cnt_nx = cnt;
    if (push_ok & ~pop)
      cnt_nx = cnt + CW'(1);
    else if (pop & ~push_ok)
      cnt_nx = cnt - CW'(1);
  end

  // status word assembly
  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf;
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(cnt);
  end

  // load data, side-effect free
  always_comb begin
    rdata = '0;
    if (hit & MemRead) begin
      unique case (sel)
        OFF_TXDATA: rdata = '0;
        OFF_STATUS: rdata = status;
        OFF_CYCLE:  rdata = cycle;
        OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl};
        default:    rdata = '0;
      endcase
    end
  end

  // overflow, cycle counter, ctrl, irq
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf   <= 1'b0;
      cycle <= '0;
      ctrl  <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_tx & ~push_ok)
        ovf <= 1'b1;
      else if (wr_st & wd[ST_OVF])
        ovf <= 1'b0;
      cycle <= wr_cy ? wd : cycle + 32'd1;
      if (wr_ct) ctrl <= wd[CTRL_W-1:0];
      irq <= ctrl[CTRL_IRQ_EN] &
             (ctrl[CTRL_IRQ_ON_EMPTY] ?
              (cnt_nx == '0) :
              (cnt_nx != CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// mmio_console bench
// directed table plus randomized run against a queue model
module tb_mmio_console;

  localparam logic [31:0] B = 32'hFFFF_0000;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wd;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  mmio_console #(.BASE(B), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .wd       (wd),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .rdata    (rdata),
    .hit      (hit),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          rd;
    bit          wr;
    bit          rdy;
    bit          chk;
    logic [31:0] erd;
    bit          ev;
    logic [7:0]  ed;
    bit          ei;
  } vec_t;

  vec_t tbl[$];
  int   n;
  int   fails;

  // reference model state
  bit [7:0]  q[$];
  bit        m_ovf;
  bit [31:0] m_cyc;
  bit [1:0]  m_ctrl;
  bit        m_irq;
  bit        mv;

  function automatic vec_t mk(bit rst, logic [31:0] addr,
    logic [31:0] d, bit rd, bit wr, bit rdy, bit c,
    logic [31:0] erd, bit ev, logic [7:0] ed, bit ei);
    vec_t v;
    v.rst = rst; v.addr = addr; v.wd = d;
    v.rd = rd; v.wr = wr; v.rdy = rdy; v.chk = c;
    v.erd = erd; v.ev = ev; v.ed = ed; v.ei = ei;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rdata(vec_t v);
    bit [31:0] st;
    if (v.addr[31:4] != B[31:4] || !v.rd) return 32'd0;
    case (v.addr[3:2])
      2'd1: begin
        st = 32'(q.size()) << 8;
        if (q.size() == DEPTH) st[0] = 1'b1;
        if (q.size() == 0)     st[1] = 1'b1;
        st[2] = m_ovf;
        return st;
      end
      2'd2:    return m_cyc;
      2'd3:    return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_upd(vec_t v);
    bit h, pop, push;
    int sel, sz;
    if (v.rst) begin
      q.delete();
      m_ovf = 0; m_cyc = 0; m_ctrl = 0; m_irq = 0;
      mv = 1;
      return;
    end
    if (!mv) return;
    h    = (v.addr[31:4] == B[31:4]);
    sel  = int'(v.addr[3:2]);
    sz   = q.size();
    pop  = (sz > 0) && v.rdy;
    push = h && v.wr && sel == 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(v.wd[7:0]);
      else m_ovf = 1;
    end
    if (h && v.wr && sel == 1 && v.wd[2]) m_ovf = 0;
    if (h && v.wr && sel == 2) m_cyc = v.wd;
    else m_cyc = m_cyc + 1;
    m_irq = m_ctrl[0] &&
            (m_ctrl[1] ? q.size() == 0 : q.size() != DEPTH);
    if (h && v.wr && sel == 3) m_ctrl = v.wd[1:0];
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    reset    = v.rst;
    address  = v.addr;
    wd       = v.wd;
    MemRead  = v.rd;
    MemWrite = v.wr;
    tx_ready = v.rdy;
    #1;
    if (mv) begin
      check("model hit", 32'(hit),
            32'(v.addr[31:4] == B[31:4]));
      check("model rdata", rdata, m_rdata(v));
      check("model tx_valid", 32'(tx_valid),
            32'(q.size() != 0));
      check("model tx_data", 32'(tx_data),
            q.size() != 0 ? 32'(q[0]) : 32'd0);
      check("model irq", 32'(irq), 32'(m_irq));
    end
    if (v.chk) begin
      check("tbl rdata", rdata, v.erd);
      check("tbl tx_valid", 32'(tx_valid), 32'(v.ev));
      check("tbl tx_data", 32'(tx_data), 32'(v.ed));
      check("tbl irq", 32'(irq), 32'(v.ei));
    end
    @(posedge clk);
    model_upd(v);
  endtask

  initial begin
    vec_t v;
    int   pr;
    n = 0; fails = 0; mv = 0;
    reset = 1; address = 0; wd = 0;
    MemRead = 0; MemWrite = 0; tx_ready = 0;

    tbl.push_back(mk(1, B, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, B, 'h41, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, B, 'h42, 0, 1, 0, 1, 0, 1, 'h41, 0));
    tbl.push_back(mk(0, B, 'h43, 0, 1, 0, 1, 0, 1, 'h41, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 'h300, 1, 'h41, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1, 'h41, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1, 'h42, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1, 'h43, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0, B, 32'h10 + i, 0, 1, 0, 1, 0,
                       i > 0, i > 0 ? 8'h10 : 8'h00, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 'h805, 1, 'h10, 0));
    tbl.push_back(mk(0, B+4, 4, 1, 1, 0, 1, 'h805, 1, 'h10, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 'h801, 1, 'h10, 0));
    tbl.push_back(mk(0, B, 'h55, 0, 1, 1, 1, 0, 1, 'h10, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 'h801, 1, 'h11, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1,
                       8'h11 + 8'(i), 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1, 'h55, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, B+8, 32'hFFFF_FFFE, 0, 1, 0, 1,
                     0, 0, 0, 0));
    tbl.push_back(mk(0, B+8, 0, 1, 0, 0, 1, 32'hFFFF_FFFE,
                     0, 0, 0));
    tbl.push_back(mk(0, B+8, 0, 1, 0, 0, 1, 32'hFFFF_FFFF,
                     0, 0, 0));
    tbl.push_back(mk(0, B+8, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, B+'hC, 3, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, B+'hC, 0, 1, 0, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, B, 'h77, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, B, 0, 0, 0, 1, 1, 0, 1, 'h77, 0));
    tbl.push_back(mk(0, B, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, B, 'hA1, 0, 1, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, B, 32'hA2 + i, 0, 1, 0, 1, 0, 1,
                       'hA1, 0));
    tbl.push_back(mk(1, B, 'hBB, 0, 1, 1, 1, 0, 1, 'hA1, 0));
    tbl.push_back(mk(0, B+4, 0, 1, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, B+8, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1234_5004, 0, 1, 0, 0, 1,
                     0, 0, 0, 0));
    tbl.push_back(mk(0, B+'hE, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, B+7, 0, 1, 0, 0, 1, 2, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pr = $urandom_range(5, 95);
      v = mk(0, B, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 90) begin
        v.addr = B | 32'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0)
          v.addr[3:2] = 2'd0;
      end else begin
        v.addr = $urandom;
      end
      v.wd  = $urandom;
      if ($urandom_range(0, 3) == 0)
        v.wd = $urandom_range(0, 7);
      if (v.addr[3:2] == 2'd2 && $urandom_range(0, 1) == 0)
        v.wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      v.rd  = $urandom_range(0, 1);
      v.wr  = ($urandom_range(0, 99) < 45);
      v.rdy = ($urandom_range(0, 99) < pr);
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n, fails);
    $finish;
  end

endmodule
